// File: rtl/sync_fifo_fwft_flags_if.sv
// Handshake, data and status bundle of the FWFT FIFO.
// The producer/consumer side uses master; the FIFO uses slave.
interface sync_fifo_fwft_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CW         = 4
);
  logic                  i_clr;
  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_full;
  logic                  i_rd_en;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_empty;
  logic [CW-1:0]         o_count;
  logic [CW-1:0]         i_afull_thresh;
  logic [CW-1:0]         i_aempty_thresh;
  logic                  o_almost_full;
  logic                  o_almost_empty;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_clr, i_wr_en, i_wr_data, i_rd_en, i_afull_thresh, i_aempty_thresh,
    input  o_full, o_rd_data, o_empty, o_count, o_almost_full, o_almost_empty,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_clr, i_wr_en, i_wr_data, i_rd_en, i_afull_thresh, i_aempty_thresh,
    output o_full, o_rd_data, o_empty, o_count, o_almost_full, o_almost_empty,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_fwft_flags.sv
// Single-clock first-word-fall-through FIFO with fill level, almost flags and
// sticky overflow/underflow; any DEPTH >= 2, optional registered output stage.
module sync_fifo_fwft_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int OUTPUT_REG = 1,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input logic                   clk,
  input logic                   rst_n,
  sync_fifo_fwft_flags_if.slave bus
);
  // With the output register enabled it holds one of the DEPTH entries.
  localparam int SD = (OUTPUT_REG != 0) ? DEPTH - 1 : DEPTH;
  localparam int PW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [SD];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  empty;
  logic                  full;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_pop;
  logic                  overflow;
  logic                  underflow;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == SD - 1) return '0;
    return p + 1'b1;
  endfunction

  assign full   = (count == FULL_CNT);
  assign wr_acc = bus.i_wr_en && !full && !bus.i_clr;
  assign rd_acc = bus.i_rd_en && !empty && !bus.i_clr;

  always_comb begin
    count_nxt = count;
    if (bus.i_clr)              count_nxt = '0;
    else if (wr_acc && !rd_acc) count_nxt = count + 1'b1;
    else if (rd_acc && !wr_acc) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (bus.i_clr) begin
        wptr      <= '0;
        rptr      <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc)                 wptr      <= ptr_inc(wptr);
        if (mem_pop)                rptr      <= ptr_inc(rptr);
        if (bus.i_wr_en && full)    overflow  <= 1'b1;
        if (bus.i_rd_en && empty)   underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= bus.i_wr_data;
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [CW-1:0]         stored;
    logic                  load;

    // Refill the output stage whenever it is free or being popped this cycle.
    assign stored  = count - CW'(vld_p1);
    assign load    = (!vld_p1 || rd_acc) && (stored != '0) && !bus.i_clr;
    assign mem_pop = load;
    assign empty   = !vld_p1;

    // Output stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          vld_p1 <= 1'b0;
      else if (bus.i_clr)  vld_p1 <= 1'b0;
      else if (load)       vld_p1 <= 1'b1;
      else if (rd_acc)     vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (load) data_p1 <= mem[rptr];
    end

    assign bus.o_rd_data = vld_p1 ? data_p1 : '0;
  end else begin : g_direct
    assign empty         = (count == '0);
    assign mem_pop       = rd_acc;
    assign bus.o_rd_data = empty ? '0 : mem[rptr];
  end

  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_count        = count;
  assign bus.o_almost_full  = (count >= bus.i_afull_thresh);
  assign bus.o_almost_empty = (count <= bus.i_aempty_thresh);
  assign bus.o_overflow     = overflow;
  assign bus.o_underflow    = underflow;
endmodule

// File: tb/tb_sync_fifo_fwft_flags.sv
// Bench for sync_fifo_fwft_flags: u0 is DEPTH=4 unregistered, u1 is DEPTH=5
// with the output register; both see the same directed stimulus.
module tb_sync_fifo_fwft_flags;
  localparam int DW   = 8;
  localparam int CW   = 3;
  localparam int LOGN = 1024;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          clr     = 1'b0;
  logic          wr_en   = 1'b0;
  logic          rd_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [CW-1:0] aft     = 3'd4;
  logic [CW-1:0] aet     = 3'd1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft_flags_if #(.DATA_WIDTH(DW), .CW(CW)) if0 ();
  sync_fifo_fwft_flags_if #(.DATA_WIDTH(DW), .CW(CW)) if1 ();

  assign if0.i_clr = clr;   assign if0.i_wr_en = wr_en; assign if0.i_wr_data = wr_data;
  assign if0.i_rd_en = rd_en; assign if0.i_afull_thresh = aft; assign if0.i_aempty_thresh = aet;
  assign if1.i_clr = clr;   assign if1.i_wr_en = wr_en; assign if1.i_wr_data = wr_data;
  assign if1.i_rd_en = rd_en; assign if1.i_afull_thresh = aft; assign if1.i_aempty_thresh = aet;

  sync_fifo_fwft_flags #(.DATA_WIDTH(DW), .DEPTH(4), .OUTPUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  sync_fifo_fwft_flags #(.DATA_WIDTH(DW), .DEPTH(5), .OUTPUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  logic [DW-1:0] a_rd  [2];
  logic [CW-1:0] a_cnt [2];
  logic a_emp [2], a_full [2], a_af [2], a_ae [2], a_ov [2], a_un [2];

  assign a_rd[0] = if0.o_rd_data;  assign a_rd[1] = if1.o_rd_data;
  assign a_cnt[0] = if0.o_count;   assign a_cnt[1] = if1.o_count;
  assign a_emp[0] = if0.o_empty;   assign a_emp[1] = if1.o_empty;
  assign a_full[0] = if0.o_full;   assign a_full[1] = if1.o_full;
  assign a_af[0] = if0.o_almost_full;  assign a_af[1] = if1.o_almost_full;
  assign a_ae[0] = if0.o_almost_empty; assign a_ae[1] = if1.o_almost_empty;
  assign a_ov[0] = if0.o_overflow; assign a_ov[1] = if1.o_overflow;
  assign a_un[0] = if0.o_underflow; assign a_un[1] = if1.o_underflow;

  // Model: log of accepted writes with the edge number at which each was taken.
  logic [DW-1:0] log_d [2][LOGN];
  int            log_t [2][LOGN];
  int            wr_tot [2];
  int            rd_tot [2];
  bit            m_ov [2];
  bit            m_un [2];
  int            cyc = 0;

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int m_size(input int i);
    return wr_tot[i] - rd_tot[i];
  endfunction

  // A head word becomes readable LAT edges after the edge that stored it.
  function automatic bit m_empty(input int i);
    if (m_size(i) == 0) return 1'b1;
    return log_t[i][rd_tot[i] % LOGN] > cyc - lat(i);
  endfunction

  function automatic bit m_full(input int i);
    return m_size(i) == dep(i);
  endfunction

  function automatic int m_head(input int i);
    return int'(log_d[i][rd_tot[i] % LOGN]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_tot[i] = 0; rd_tot[i] = 0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit e, f;
        e = m_empty(i);
        f = m_full(i);
        if (clr) begin
          rd_tot[i] = wr_tot[i]; m_ov[i] = 1'b0; m_un[i] = 1'b0;
        end else begin
          if (wr_en && f) m_ov[i] = 1'b1;
          if (rd_en && e) m_un[i] = 1'b1;
          if (rd_en && !e) rd_tot[i]++;
          if (wr_en && !f) begin
            log_d[i][wr_tot[i] % LOGN] = wr_data;
            log_t[i][wr_tot[i] % LOGN] = cyc + 1;
            wr_tot[i]++;
          end
        end
      end
      cyc++;
    end
  end

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got 0x%0h, want 0x%0h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("count", i, int'(a_cnt[i]), m_size(i));
      chk("empty", i, int'(a_emp[i]), int'(m_empty(i)));
      chk("full", i, int'(a_full[i]), int'(m_full(i)));
      chk("almost_full", i, int'(a_af[i]), int'(m_size(i) >= int'(aft)));
      chk("almost_empty", i, int'(a_ae[i]), int'(m_size(i) <= int'(aet)));
      chk("overflow", i, int'(a_ov[i]), int'(m_ov[i]));
      chk("underflow", i, int'(a_un[i]), int'(m_un[i]));
      if (!rst_n)             chk("rd_data_rst", i, int'(a_rd[i]), 0);
      else if (!m_empty(i))   chk("rd_data", i, int'(a_rd[i]), m_head(i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_count"}, i, int'(a_cnt[i]), 0);
      chk({nm, "_empty"}, i, int'(a_emp[i]), 1);
      chk({nm, "_full"}, i, int'(a_full[i]), 0);
      chk({nm, "_ov"}, i, int'(a_ov[i]), 0);
      chk({nm, "_un"}, i, int'(a_un[i]), 0);
    end
  endtask

  initial begin
    logic [7:0] seq4 [4];
    seq4 = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset state
    repeat (2) tick();
    chk_reset_state("rst");
    chk("rst_rd_data", 0, int'(a_rd[0]), 0);
    chk("rst_rd_data", 1, int'(a_rd[1]), 0);
    chk("rst_afull", 0, int'(a_af[0]), 0);
    chk("rst_aempty", 1, int'(a_ae[1]), 1);
    rst_n = 1'b1;
    tick();

    // Fill u0 to full, then drain in order
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; wr_data = seq4[k]; tick();
    end
    wr_en = 1'b0;
    chk("fill_count", 0, int'(a_cnt[0]), 4);
    chk("fill_full", 0, int'(a_full[0]), 1);
    chk("fill_afull", 0, int'(a_af[0]), 1);
    chk("fill_count", 1, int'(a_cnt[1]), 4);
    chk("fill_full", 1, int'(a_full[1]), 0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_data", 0, int'(a_rd[0]), int'(seq4[k]));
      rd_en = 1'b1; tick();
    end
    rd_en = 1'b0;
    chk("drain_empty", 0, int'(a_emp[0]), 1);
    chk("drain_count", 0, int'(a_cnt[0]), 0);

    // Registered-output latency
    wr_en = 1'b1; wr_data = 8'hA5; tick();
    wr_en = 1'b0;
    chk("oreg_c1_count", 1, int'(a_cnt[1]), 1);
    chk("oreg_c1_empty", 1, int'(a_emp[1]), 1);
    chk("direct_c1_data", 0, int'(a_rd[0]), 8'hA5);
    tick();
    chk("oreg_c2_empty", 1, int'(a_emp[1]), 0);
    chk("oreg_c2_data", 1, int'(a_rd[1]), 8'hA5);
    rd_en = 1'b1; tick(); rd_en = 1'b0;

    // Full plus simultaneous read and write
    for (int k = 1; k <= 4; k++) begin
      wr_en = 1'b1; wr_data = 8'(k); tick();
    end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("full_rw_ov", 0, int'(a_ov[0]), 1);
    chk("full_rw_count", 0, int'(a_cnt[0]), 3);
    chk("full_rw_head", 0, int'(a_rd[0]), 8'h02);
    chk("full_rw_count", 1, int'(a_cnt[1]), 4);
    for (int k = 2; k <= 4; k++) begin
      chk("full_rw_drain", 0, int'(a_rd[0]), k);
      rd_en = 1'b1; tick();
    end
    rd_en = 1'b0;
    chk("kept_99", 1, int'(a_rd[1]), 8'h99);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rd_empty_un", 0, int'(a_un[0]), 1);
    chk("rd_ok_un", 1, int'(a_un[1]), 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_un", 0, int'(a_un[0]), 0);

    // Empty plus simultaneous read and write
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("empty_rw_un", 0, int'(a_un[0]), 1);
    chk("empty_rw_count", 0, int'(a_cnt[0]), 1);
    chk("empty_rw_data", 0, int'(a_rd[0]), 8'h5A);
    chk("empty_rw_un", 1, int'(a_un[1]), 1);
    tick();
    chk("empty_rw_data", 1, int'(a_rd[1]), 8'h5A);
    rd_en = 1'b1; tick(); rd_en = 1'b0;

    // Streaming across the pointer wrap
    for (int k = 0; k < 12; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + k); rd_en = (k % 2 == 1); tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    repeat (6) tick();
    rd_en = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;

    // Mixed pattern with threshold sweeps
    for (int k = 0; k < 40; k++) begin
      wr_en = (k % 4 != 3); rd_en = (k % 3 == 2) || (k >= 28);
      wr_data = 8'(k * 5 + 1);
      aft = (k >= 10 && k < 16) ? 3'd0 : 3'(2 + k % 4);
      aet = (k >= 10 && k < 16) ? 3'd5 : 3'(k % 3);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    aft = 3'd0; aet = 3'd5; #1;
    for (int i = 0; i < 2; i++) begin
      chk("thr0_afull", i, int'(a_af[i]), 1);
      chk("thrmax_aempty", i, int'(a_ae[i]), 1);
    end
    aft = 3'd4; aet = 3'd1;
    clr = 1'b1; tick(); clr = 1'b0;

    // Clear with overflow set and a write in the same cycle
    for (int k = 1; k <= 5; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + k); tick();
    end
    wr_en = 1'b0; rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("pre_clr_count", 0, int'(a_cnt[0]), 3);
    chk("pre_clr_ov", 0, int'(a_ov[0]), 1);
    chk("pre_clr_head", 0, int'(a_rd[0]), 8'hC2);
    chk("pre_clr_count", 1, int'(a_cnt[1]), 4);
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; tick();
    clr = 1'b0; wr_en = 1'b0;
    chk_reset_state("clr");
    tick();
    chk("clr_nowrite", 0, int'(a_cnt[0]), 0);
    chk("clr_nowrite", 1, int'(a_cnt[1]), 0);

    // Asynchronous reset in the middle of a stream
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'hD1 + k); tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("arst");
    chk("arst_rd_data", 0, int'(a_rd[0]), 0);
    chk("arst_rd_data", 1, int'(a_rd[1]), 0);
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1; wr_data = 8'h77; tick(); wr_en = 1'b0;
    tick();
    chk("post_rst_data", 1, int'(a_rd[1]), 8'h77);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
